// File: rtl/axis_pow2_framer.sv
// AXI-Stream framer: asserts tlast on every 2^k-th beat. k is sampled and clamped at each packet start.
// The output side is a registered 2-entry skid buffer (output register plus skid register).
module axis_pow2_framer #(
  parameter int DATA_WIDTH     = 32,
  parameter int MIN_POWER_OF_2 = 5,
  parameter int MAX_POWER_OF_2 = 7,
  parameter int EXP_WIDTH      = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [EXP_WIDTH-1:0]  cfg_log2_len,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic                  cfg_clamped
);

  localparam int CW = MAX_POWER_OF_2 + 1;

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t                state_reg;
  logic [EXP_WIDTH-1:0]  k_reg;
  logic [CW-1:0]         beat_cnt_reg;
  logic [DATA_WIDTH-1:0] out_data_reg, skid_data_reg;
  logic                  out_valid_reg, out_last_reg;
  logic                  skid_valid_reg, skid_last_reg;
  logic                  tready_reg;
  logic [CNT_WIDTH-1:0]  pkt_count_reg;
  logic                  clamped_reg;

  logic                  accept, send;
  logic                  cfg_low, cfg_high;
  logic [EXP_WIDTH-1:0]  k_sampled, k_cur;
  logic [CW-1:0]         pkt_len, cnt_next;
  logic                  in_last;
  logic                  out_load_new, out_load_skid, skid_load;
  logic                  out_valid_next, skid_valid_next;

  assign accept = s_axis_tvalid & tready_reg;
  assign send   = out_valid_reg & m_axis_tready;

  // Packet length: exponent from the live config at packet start, from the latched copy afterwards.
  always_comb begin
    cfg_low   = cfg_log2_len < EXP_WIDTH'(MIN_POWER_OF_2);
    cfg_high  = cfg_log2_len > EXP_WIDTH'(MAX_POWER_OF_2);
    k_sampled = cfg_log2_len;
    if (cfg_low)  k_sampled = EXP_WIDTH'(MIN_POWER_OF_2);
    if (cfg_high) k_sampled = EXP_WIDTH'(MAX_POWER_OF_2);
    k_cur    = (state_reg == IDLE) ? k_sampled : k_reg;
    pkt_len  = CW'(1) << k_cur;
    cnt_next = (state_reg == IDLE) ? CW'(1) : beat_cnt_reg + CW'(1);
    in_last  = (cnt_next == pkt_len);
  end

  // A new beat goes straight to the output register when it is free (or being freed with no skid
  // backlog); otherwise it parks in the skid register.
  always_comb begin
    out_load_new    = accept & (~out_valid_reg | (send & ~skid_valid_reg));
    out_load_skid   = send & skid_valid_reg;
    skid_load       = accept & ~out_load_new;
    out_valid_next  = out_load_new | out_load_skid | (out_valid_reg & ~send);
    skid_valid_next = skid_load | (skid_valid_reg & ~send);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      k_reg          <= '0;
      beat_cnt_reg   <= '0;
      out_data_reg   <= '0;
      out_last_reg   <= 1'b0;
      out_valid_reg  <= 1'b0;
      skid_data_reg  <= '0;
      skid_last_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      tready_reg     <= 1'b0;
      pkt_count_reg  <= '0;
      clamped_reg    <= 1'b0;
    end else begin
      tready_reg     <= ~skid_valid_next;
      out_valid_reg  <= out_valid_next;
      skid_valid_reg <= skid_valid_next;

      if (out_load_skid) begin
        out_data_reg <= skid_data_reg;
        out_last_reg <= skid_last_reg;
      end else if (out_load_new) begin
        out_data_reg <= s_axis_tdata;
        out_last_reg <= in_last;
      end

      if (skid_load) begin
        skid_data_reg <= s_axis_tdata;
        skid_last_reg <= in_last;
      end

      if (accept) begin
        beat_cnt_reg <= in_last ? '0 : cnt_next;
        state_reg    <= in_last ? IDLE : IN_PKT;
        if (state_reg == IDLE) begin
          k_reg <= k_sampled;
          if (cfg_low | cfg_high) clamped_reg <= 1'b1;
        end
      end

      if (send & out_last_reg) pkt_count_reg <= pkt_count_reg + CNT_WIDTH'(1);
    end
  end

  assign s_axis_tready = tready_reg;
  assign m_axis_tdata  = out_data_reg;
  assign m_axis_tvalid = out_valid_reg;
  assign m_axis_tlast  = out_last_reg;
  assign pkt_count     = pkt_count_reg;
  assign cfg_clamped   = clamped_reg;

endmodule

// File: tb/tb_axis_pow2_framer.sv
// Scoreboard bench for axis_pow2_framer: the driver pushes expected beats from a packet-length model,
// and an independent monitor pops and compares on every output handshake.
module tb_axis_pow2_framer;

  localparam int MINP = 5;
  localparam int MAXP = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cfg_log2_len = 4'd5;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic [15:0] pkt_count;
  logic        cfg_clamped;

  axis_pow2_framer dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_log2_len  (cfg_log2_len),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .pkt_count     (pkt_count),
    .cfg_clamped   (cfg_clamped)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    mode = 0;          // 0: ready high, 1: ready low, 2: random stalls up to 42 cycles
  int    out_total = 0;
  int    out_cyc[4096];
  int    acc_cnt = 0;
  int    last_acc_cyc = 0;
  int    pos = 0;           // beats of the current packet already accepted
  int    plen = 1;
  bit    drv_done = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: packet length is 2^clamp(cfg) fixed at the first beat of each packet.
  function automatic void model_accept(input logic [31:0] d, input logic [3:0] cfg);
    beat_t b;
    int k;
    if (pos == 0) begin
      k = int'(cfg);
      if (k < MINP) k = MINP;
      if (k > MAXP) k = MAXP;
      plen = 1 << k;
    end
    pos++;
    b.d = d;
    b.l = (pos == plen);
    if (b.l) pos = 0;
    exp_q.push_back(b);
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Called on a negedge; returns on the negedge after the beat is accepted.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] cfg, input int max_gap);
    int t;
    int gap;
    gap = 0;
    if (max_gap > 0 && $urandom_range(0, 3) == 0) gap = $urandom_range(1, max_gap);
    for (int i = 0; i < gap; i++) @(negedge clk);
    cfg_log2_len  = cfg;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    t = 0;
    while (!s_axis_tready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got no tready after %0d cycles expected tready", t);
    end else begin
      last_acc_cyc = cyc;
      acc_cnt++;
      model_accept(d, cfg);
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("drain_done", (t < 5000) ? 1 : 0, 1);
  endtask

  // Monitor: drives m_axis_tready and checks every output handshake against the scoreboard.
  initial begin
    bit          stalled;
    logic [31:0] st_d;
    logic        st_l;
    int          stall_left;
    logic        r;
    beat_t       e;
    stalled    = 1'b0;
    stall_left = 0;
    st_d       = '0;
    st_l       = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          n_vec++;
          if (!m_axis_tvalid || m_axis_tdata != st_d || m_axis_tlast != st_l) begin
            n_err++;
            $display("FAIL stall_stable: got v=%0b d=%h l=%0b expected v=1 d=%h l=%0b",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast, st_d, st_l);
          end
        end
        r = 1'b1;
        if (mode == 1) r = 1'b0;
        else if (mode == 2) begin
          if (stall_left > 0) begin
            r = 1'b0;
            stall_left--;
          end else if ($urandom_range(0, 3) == 0) begin
            r = 1'b0;
            stall_left = $urandom_range(1, 42) - 1;
          end
        end
        m_axis_tready = r;
        if (m_axis_tvalid && r) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: got d=%h l=%0b expected no beat", m_axis_tdata, m_axis_tlast);
          end else begin
            e = exp_q.pop_front();
            n_vec++;
            if (m_axis_tdata != e.d || m_axis_tlast != e.l) begin
              n_err++;
              $display("FAIL beat %0d: got d=%h l=%0b expected d=%h l=%0b",
                       out_total, m_axis_tdata, m_axis_tlast, e.d, e.l);
            end
          end
          if (out_total < 4096) out_cyc[out_total] = cyc;
          out_total++;
        end
        stalled = m_axis_tvalid && !r;
        st_d    = m_axis_tdata;
        st_l    = m_axis_tlast;
      end
    end
  end

  initial begin
    int base;
    int acc0;
    int t;
    void'($urandom(3393937));

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tready", s_axis_tready, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_clamped", cfg_clamped, 0);
    rst = 1'b0;
    @(negedge clk);
    check("tready_after_rst", s_axis_tready, 1);

    // 1: 96 beats 0..95, continuous, k=5
    mode = 0;
    base = out_total;
    send_beat(32'd0, 4'd5, 0);
    acc0 = last_acc_cyc;
    for (int i = 1; i < 96; i++) send_beat(32'(i), 4'd5, 0);
    drain();
    check("t1_first_latency", out_cyc[base] - acc0, 1);
    check("t1_no_bubbles", out_cyc[base + 95] - out_cyc[base], 95);
    check("t1_pkt_count", pkt_count, 3);
    check("t1_clamped", cfg_clamped, 0);

    // 2: below-min clamps to 32, above-max clamps to 128
    for (int i = 0; i < 64; i++) send_beat($urandom, 4'd2, 0);
    drain();
    check("t2_clamped_low", cfg_clamped, 1);
    check("t2_pkt_count_a", pkt_count, 5);
    for (int i = 0; i < 256; i++) send_beat($urandom, 4'd9, 0);
    drain();
    check("t2_clamped_sticky", cfg_clamped, 1);
    check("t2_pkt_count_b", pkt_count, 7);

    // 3: mid-packet config change has no effect on the current packet
    for (int i = 0; i < 32; i++) send_beat($urandom, (i < 10) ? 4'd5 : 4'd7, 0);
    for (int i = 0; i < 128; i++) send_beat($urandom, 4'd7, 0);
    drain();
    check("t3_pkt_count", pkt_count, 9);

    // 4: random gaps on both sides, 8 packets of 32
    mode = 2;
    for (int i = 0; i < 256; i++) send_beat($urandom, 4'd5, 17);
    drain();
    mode = 0;
    check("t4_pkt_count", pkt_count, 17);

    // 5: output blocked -> exactly two beats accepted, then released
    mode = 1;
    @(negedge clk);
    acc_cnt  = 0;
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 64; i++) send_beat($urandom, 4'd5, 0);
        drv_done = 1'b1;
      end
    join_none
    repeat (12) @(negedge clk);
    check("t5_accepted", acc_cnt, 2);
    check("t5_tready_low", s_axis_tready, 0);
    check("t5_tvalid_held", m_axis_tvalid, 1);
    mode = 0;
    t = 0;
    while (!drv_done && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("t5_driver_done", drv_done, 1);
    drain();
    check("t5_pkt_count", pkt_count, 19);

    // 6: reset mid-packet, then a fresh 32-beat packet
    for (int i = 0; i < 2; i++) send_beat($urandom, 4'd2, 0);
    for (int i = 0; i < 18; i++) send_beat($urandom, 4'd5, 0);
    drain();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    pos = 0;
    @(negedge clk);
    rst = 1'b0;
    check("t6_tvalid", m_axis_tvalid, 0);
    check("t6_pkt_count", pkt_count, 0);
    check("t6_clamped_cleared", cfg_clamped, 0);
    check("t6_tready_in_rst", s_axis_tready, 0);
    @(negedge clk);
    check("t6_tready_after", s_axis_tready, 1);
    for (int i = 0; i < 32; i++) send_beat($urandom, 4'd5, 0);
    drain();
    check("t6_pkt_count_after", pkt_count, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
